// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle execute stage feeding the flag register.
// Define ALU_MUL_EN to include the iterative shift-add multiplier on opcode 8.
module alu_exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             C,
  output logic             N,
  output logic             Z,
  output logic             OV,
  output logic             execute,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam int         CW     = $clog2(WIDTH + 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_q, c_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             ov_q, ov_d;
  logic             execute_q, execute_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_ov;
  logic             alu_legal;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_sum;

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
`endif

  // Single-cycle datapath; SUB reuses the adder as a + ~b + 1.
  always_comb begin
    b_op      = (op_q == OP_SUB) ? ~b_q : b_q;
    add_sum   = {1'b0, a_q} + {1'b0, b_op} + {{WIDTH{1'b0}}, (op_q == OP_SUB)};
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_ov    = 1'b0;
    alu_legal = 1'b1;
    case (op_q)
      OP_ADD, OP_SUB: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_ov  = (a_q[WIDTH-1] == b_op[WIDTH-1]) &&
                  (add_sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SHL: begin
        alu_res = {a_q[WIDTH-2:0], 1'b0};
        alu_c   = a_q[WIDTH-1];
        alu_ov  = a_q[WIDTH-1] ^ a_q[WIDTH-2];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_q[WIDTH-1:1]};
        alu_c   = a_q[0];
      end
      default: alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    c_d       = c_q;
    n_d       = n_q;
    z_d       = z_q;
    ov_d      = ov_q;
    execute_d = 1'b0;
    illegal_d = 1'b0;
`ifdef ALU_MUL_EN
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
`ifdef ALU_MUL_EN
        if (op_q == OP_MUL) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, a_q};
          mplier_d = b_q;
          cnt_d    = CW'(WIDTH);
          state_d  = ST_MUL;
        end else
`endif
        if (alu_legal) begin
          result_d  = alu_res;
          c_d       = alu_c;
          ov_d      = alu_ov;
          n_d       = alu_res[WIDTH-1];
          z_d       = (alu_res == '0);
          execute_d = 1'b1;
        end else begin
          illegal_d = 1'b1;
        end
      end
      ST_MUL: begin
`ifdef ALU_MUL_EN
        acc_d    = acc_sum;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - CW'(1);
        // Last partial product is folded in on the same edge the result is published.
        if (cnt_q == CW'(1)) begin
          result_d  = acc_sum[WIDTH-1:0];
          c_d       = |acc_sum[2*WIDTH-1:WIDTH];
          ov_d      = |acc_sum[2*WIDTH-1:WIDTH];
          n_d       = acc_sum[WIDTH-1];
          z_d       = (acc_sum[WIDTH-1:0] == '0);
          execute_d = 1'b1;
          state_d   = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      c_q       <= 1'b0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      ov_q      <= 1'b0;
      execute_q <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      c_q       <= c_d;
      n_q       <= n_d;
      z_q       <= z_d;
      ov_q      <= ov_d;
      execute_q <= execute_d;
      illegal_q <= illegal_d;
`ifdef ALU_MUL_EN
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign result  = result_q;
  assign C       = c_q;
  assign N       = n_q;
  assign Z       = z_q;
  assign OV      = ov_q;
  assign execute = execute_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: arithmetic reference model plus directed vectors.
// Honours ALU_MUL_EN the same way as the design.
module tb_alu_exec_unit;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic [W-1:0] result;
  logic         C, N, Z, OV, execute, illegal;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  logic [W-1:0] last_res = '0;
  logic [3:0]   last_flags = '0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .result(result), .C(C), .N(N), .Z(Z), .OV(OV),
    .execute(execute), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic; returns {legal, result, C, OV}.
  function automatic logic [W+2:0] model_op(input int op_v, input int av, input int bv);
    int full, half, sa, sb, r, c, ov;
    longint p;
    bit legal;
    logic [W-1:0] rr;
    full = 1 << W;
    half = 1 << (W - 1);
    sa = (av >= half) ? av - full : av;
    sb = (bv >= half) ? bv - full : bv;
    r = 0; c = 0; ov = 0; legal = 1'b1; p = 0;
    case (op_v)
      0: begin r = av + bv; c = r / full; ov = (sa + sb >= half || sa + sb < -half) ? 1 : 0; end
      1: begin r = av + (full - 1 - bv) + 1; c = r / full; ov = (sa - sb >= half || sa - sb < -half) ? 1 : 0; end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: r = full - 1 - av;
      6: begin r = av * 2; c = av / half; ov = c ^ ((av / (half / 2)) % 2); end
      7: begin r = av / 2; c = av % 2; end
      8: begin
        if (MUL_EN) begin
          p = longint'(av) * longint'(bv);
          r = int'(p % longint'(full));
          c = (p >= longint'(full)) ? 1 : 0;
          ov = c;
        end else legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    r = r % full;
    rr = r[W-1:0];
    return {legal, rr, (c != 0), (ov != 0)};
  endfunction

  int           m_rem = 0;
  logic [W+2:0] m_pend = '0;
  logic [W-1:0] m_res = '0;
  logic         m_c = 0, m_n = 0, m_z = 0, m_ov = 0, m_exec = 0, m_ill = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0; m_pend <= '0; m_res <= '0;
      m_c <= 0; m_n <= 0; m_z <= 0; m_ov <= 0; m_exec <= 0; m_ill <= 0;
    end else begin
      m_exec <= 0;
      m_ill  <= 0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          if (m_pend[W+2]) begin
            m_res  <= m_pend[W+1:2];
            m_c    <= m_pend[1];
            m_ov   <= m_pend[0];
            m_n    <= m_pend[W+1];
            m_z    <= (m_pend[W+1:2] == '0);
            m_exec <= 1;
          end else begin
            m_ill <= 1;
          end
        end
      end else if (start) begin
        m_pend <= model_op(int'(op), int'(a), int'(b));
        m_rem  <= (op == 4'd8 && MUL_EN) ? W + 1 : 1;
      end
    end
  end

  logic [W+6:0] cmp_act, cmp_exp;
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_act = {busy, execute, illegal, result, C, N, Z, OV};
      cmp_exp = {(m_rem != 0), m_exec, m_ill, m_res, m_c, m_n, m_z, m_ov};
      tests++;
      if (cmp_act !== cmp_exp) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t {busy,exec,ill,result,C,N,Z,OV} actual=%h required=%h",
                 $time, cmp_act, cmp_exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, got, exp_v);
    end
  endtask

  task automatic do_op(input string name, input logic [3:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input bit legal, input logic [W-1:0] er,
                       input logic [3:0] ef, input int ewait, input bit mid);
    int w;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; op = 4'hA; a = W'($urandom); b = W'($urandom);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    w = 0;
    while (!(execute || illegal) && w < 40) begin
      if (mid && w == 2) begin start = 1'b1; op = 4'd0; a = 8'h01; b = 8'h01; end
      else start = 1'b0;
      @(negedge clk);
      w++;
    end
    start = 1'b0;
    chk({name, "_latency"}, 32'(w), 32'(ewait));
    if (legal) begin
      chk({name, "_execute"}, 32'(execute), 32'd1);
      chk({name, "_result"}, 32'(result), 32'(er));
      chk({name, "_flags"}, 32'({C, N, Z, OV}), 32'(ef));
      last_res = er;
      last_flags = ef;
    end else begin
      chk({name, "_illegal"}, 32'(illegal), 32'd1);
      chk({name, "_noexec"}, 32'(execute), 32'd0);
      chk({name, "_hold_result"}, 32'(result), 32'(last_res));
      chk({name, "_hold_flags"}, 32'({C, N, Z, OV}), 32'(last_flags));
    end
    $display("[TB] %s op=%0d a=%02h b=%02h -> result=%02h CNZV=%b exec=%0b ill=%0b wait=%0d",
             name, o, av, bv, result, {C, N, Z, OV}, execute, illegal, w);
  endtask

  logic [3:0]   t_op  [8] = '{4'd3, 4'd4, 4'd5, 4'd7, 4'd6, 4'd0, 4'd1, 4'd2};
  logic [W-1:0] t_a   [8] = '{8'hA0, 8'hFF, 8'h0F, 8'h81, 8'h40, 8'hFF, 8'h80, 8'h0F};
  logic [W-1:0] t_b   [8] = '{8'h05, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'hF0};
  logic [W-1:0] t_res [8] = '{8'hA5, 8'h00, 8'hF0, 8'h40, 8'h80, 8'h00, 8'h7F, 8'h00};
  logic [3:0]   t_flg [8] = '{4'b0100, 4'b0010, 4'b0100, 4'b1000, 4'b0101, 4'b1010, 4'b1001, 4'b0010};

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("reset_state", 32'({busy, execute, illegal, result, C, N, Z, OV}), 32'd0);

    do_op("add_ovf", 4'd0, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0101, 1, 1'b0);
    @(negedge clk);
    chk("add_exec_one_cycle", 32'(execute), 32'd0);
    chk("add_busy_dropped", 32'(busy), 32'd0);

    do_op("sub_eq", 4'd1, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1010, 1, 1'b0);
    do_op("sub_borrow", 4'd1, 8'h00, 8'h01, 1'b1, 8'hFF, 4'b0100, 1, 1'b0);

    do_op("mul_10x20", 4'd8, 8'h10, 8'h20, MUL_EN, 8'h00, 4'b1011, MUL_EN ? 9 : 1, 1'b1);
    do_op("mul_0Fx11", 4'd8, 8'h0F, 8'h11, MUL_EN, 8'hFF, 4'b0100, MUL_EN ? 9 : 1, 1'b0);

    for (int i = 0; i < 8; i++)
      do_op("vec", t_op[i], t_a[i], t_b[i], 1'b1, t_res[i], t_flg[i], 1, 1'b0);

    // Back-to-back: second start rides on the first execute cycle.
    do_op("b2b_and", 4'd2, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000, 1, 1'b0);
    start = 1'b1; op = 4'd6; a = 8'hC0; b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_gap_exec", 32'(execute), 32'd0);
    chk("b2b_gap_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("b2b_shl_exec", 32'(execute), 32'd1);
    chk("b2b_shl_result", 32'(result), 32'h80);
    chk("b2b_shl_flags", 32'({C, N, Z, OV}), 32'b1100);
    $display("[TB] b2b_shl op=6 a=c0 -> result=%02h CNZV=%b exec=%0b", result, {C, N, Z, OV}, execute);

    // Async reset during the 4th multiply cycle.
    @(negedge clk);
    start = 1'b1; op = 4'd8; a = 8'h10; b = 8'h20;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mul_busy_before_rst", 32'(busy), 32'(MUL_EN));
    #2 rst_n = 1'b0;
    #1 chk("async_rst_outputs", 32'({busy, execute, illegal, result, C, N, Z, OV}), 32'd0);
    @(negedge clk);
    chk("rst_held_outputs", 32'({busy, execute, illegal, result, C, N, Z, OV}), 32'd0);
    #2 rst_n = 1'b1;
    last_res = '0;
    last_flags = '0;
    $display("[TB] reset mid-operation -> result=%02h CNZV=%b busy=%0b", result, {C, N, Z, OV}, busy);

    do_op("add_after_rst", 4'd0, 8'h01, 8'h01, 1'b1, 8'h02, 4'b0000, 1, 1'b0);
    do_op("illegal_F", 4'hF, 8'h12, 8'h34, 1'b0, 8'h00, 4'b0000, 1, 1'b0);
    @(negedge clk);
    chk("illegal_one_cycle", 32'(illegal), 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Sequential execute stage that sits directly upstream of the flag register. It accepts an opcode and two operands with a start/busy handshake and computes the result over one or more cycles (iterative shift-add for multiply). It presents registered result and C/N/Z/OV flags. It pulses `execute` for exactly one cycle when a new result and flag set are valid for the flag register to capture.

## Interface
- `WIDTH`, 8, operand/result width in bits; minimum 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  4  opcode, latched with `start`.
- `a`, `b`  in  WIDTH  operands, latched with `start`.
- `busy`  out  1  high while an accepted operation is in progress.
- `result`  out  WIDTH  registered result; holds between operations.
- `C`, `N`, `Z`, `OV`  out  1 each  registered flags; hold between operations.
- `execute`  out  1  one-cycle pulse: result/flags updated this cycle.
- `illegal`  out  1  one-cycle pulse: rejected opcode.

## Operation
- Opcodes:
  - 0 ADD `a+b`.
  - 1 SUB `a-b`, computed as `a+~b+1`.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT `~a`.
  - 6 SHL `a<<1`.
  - 7 SHR `a>>1`, logical.
  - 8 MUL, low WIDTH bits of `a*b`, unsigned.
  - 9–15 illegal.
- Flags:
  - N is always `result[WIDTH-1]`.
  - Z is always `result==0`.
  - ADD/SUB: C is the carry-out of the WIDTH-bit adder, so C=1 means no borrow on SUB. OV is two's-complement overflow.
  - AND/OR/XOR/NOT: C=0, OV=0.
  - SHL: C=`a[WIDTH-1]`, OV=`a[WIDTH-1]^a[WIDTH-2]`.
  - SHR: C=`a[0]`, OV=0.
  - MUL: C=1 iff the upper WIDTH bits of the 2·WIDTH product are nonzero. OV=C.
- FSM states: IDLE, EXEC, MUL.
  - IDLE: if `start`=1, latch op/a/b, go to EXEC. Otherwise stay.
  - EXEC, single-cycle op: register result/flags, pulse `execute`, go to IDLE.
  - EXEC, MUL: clear accumulator, load multiplier/multiplicand, counter=WIDTH, go to MUL.
  - EXEC, illegal op: pulse `illegal`, leave result/flags unchanged, go to IDLE.
  - MUL: each cycle, if multiplier LSB=1, add multiplicand to the 2·WIDTH accumulator. Then shift multiplicand left, shift multiplier right, decrement counter. On the cycle the counter reaches 0, register result/flags, pulse `execute`, go to IDLE.
- `busy` = (state != IDLE).
- `start` while busy is ignored; there is no queueing.
- `execute` and `illegal` are never high together.

## Timing
- Reset (async, `rst_n`=0): state=IDLE, `result`=0, C=N=Z=OV=0, `execute`=0, `illegal`=0, `busy`=0.
- Reset mid-operation aborts it: no `execute` pulse, outputs return to reset values.
- Start accepted at edge t:
  - `busy` is high from after t.
  - Single-cycle op: result/flags/`execute` valid after edge t+1 (latency 2 edges). `busy` drops after t+1.
  - MUL: valid after edge t+WIDTH+1. `busy` is high for WIDTH+1 cycles.
  - Illegal op: `illegal` high after edge t+1.
- `execute` is registered and lasts exactly one cycle. Flags are stable in that cycle and remain stable afterwards until the next `execute`.
- Back-to-back: `start` asserted in the cycle `execute` is high is in IDLE and is accepted. The next `execute` follows after the same latency, so single-cycle ops sustain one result every 2 cycles.
- Operands or op changing after acceptance have no effect on the operation in progress.

## Configuration
- `ALU_MUL_EN` defined: opcode 8 performs the iterative multiply, and the MUL state, counter and 2·WIDTH accumulator are present.
- `ALU_MUL_EN` undefined: multiply hardware is removed, and opcode 8 is treated as illegal (`illegal` pulse after t+1, no `execute`, outputs unchanged).
- All other opcodes are unaffected by the macro.

## Test plan
- ADD a=0x7F b=0x01, WIDTH=8 -> `result`=0x80, C=0 N=1 Z=0 OV=1. Single `execute` pulse after edge t+1. `busy` high for 1 cycle.
- SUB a=0x05 b=0x05 -> 0x00, C=1 N=0 Z=1 OV=0. SUB 0x00-0x01 -> 0xFF, C=0 N=1 OV=0.
- MUL 0x10×0x20 (`ALU_MUL_EN`) -> `result`=0x00, Z=1 C=1 OV=1. `execute` after edge t+9. A `start` pulsed mid-operation is ignored. MUL 0x0F×0x11 -> 0xFF, C=0.
- Back-to-back: AND 0xF0,0x3C issued, then SHL a=0xC0 with `start` high during the first `execute` cycle -> 0x30 (flags 0,0,0,0), then 0x80 with C=1 N=1 OV=0 exactly 2 cycles later.
- `rst_n` low at the 4th MUL cycle -> all outputs 0, no `execute`. A subsequent ADD 0x01+0x01 -> 0x02 normally.
- op=0xF (and op=8 without `ALU_MUL_EN`) -> `illegal` one-cycle pulse, no `execute`, result/flags unchanged from the prior operation.
